// File: rtl/piano_seq_ctrl_pkg.sv
// ============================================================================
// piano_seq_ctrl_pkg : shared types, song-entry field layout and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package piano_seq_ctrl_pkg;

  localparam logic [2:0] NOTE_C4 = 3'd0;
  localparam logic [2:0] NOTE_D4 = 3'd1;
  localparam logic [2:0] NOTE_E4 = 3'd2;
  localparam logic [2:0] NOTE_F4 = 3'd3;
  localparam logic [2:0] NOTE_G4 = 3'd4;
  localparam logic [2:0] NOTE_A4 = 3'd5;
  localparam logic [2:0] NOTE_B4 = 3'd6;
  localparam logic [2:0] NOTE_C5 = 3'd7;

  localparam int NOTE_MSB = 7;
  localparam int NOTE_LSB = 5;
  localparam int REST_BIT = 4;
  localparam int DUR_MSB  = 3;
  localparam int DUR_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NOTE = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // A zero duration field stands for a full 16-tick note.
  function automatic logic [4:0] entry_ticks(input logic [7:0] entry);
    logic [3:0] dur;
    dur = entry[DUR_MSB:DUR_LSB];
    return (dur == 4'd0) ? 5'd16 : {1'b0, dur};
  endfunction

  function automatic logic [7:0] entry_note_en(input logic [7:0] entry);
    return entry[REST_BIT] ? 8'h00 : (8'h01 << entry[NOTE_MSB:NOTE_LSB]);
  endfunction

  function automatic logic [7:0] lowest_onehot(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/piano_song_rom.sv
// ============================================================================
// piano_song_rom : fixed 16-entry song table, {note[2:0], rest, dur[3:0]}
// Rev 1.0
// ============================================================================
`default_nettype none

module piano_song_rom
  import piano_seq_ctrl_pkg::*;
(
  input  logic [3:0] addr_i,
  output logic [7:0] entry_o
);

  always_comb begin
    entry_o = 8'h00;
    case (addr_i)
      4'd0:  entry_o = {NOTE_C4, 1'b0, 4'd2};
      4'd1:  entry_o = {NOTE_E4, 1'b0, 4'd1};
      4'd2:  entry_o = {NOTE_C4, 1'b1, 4'd1};
      4'd3:  entry_o = {NOTE_C5, 1'b0, 4'd1};
      4'd4:  entry_o = {NOTE_D4, 1'b0, 4'd2};
      4'd5:  entry_o = {NOTE_F4, 1'b0, 4'd2};
      4'd6:  entry_o = {NOTE_G4, 1'b0, 4'd4};
      4'd7:  entry_o = {NOTE_A4, 1'b0, 4'd4};
      4'd8:  entry_o = {NOTE_B4, 1'b0, 4'd2};
      4'd9:  entry_o = {NOTE_C5, 1'b0, 4'd0};
      4'd10: entry_o = {NOTE_C4, 1'b1, 4'd2};
      4'd11: entry_o = {NOTE_G4, 1'b0, 4'd4};
      4'd12: entry_o = {NOTE_E4, 1'b0, 4'd2};
      4'd13: entry_o = {NOTE_D4, 1'b0, 4'd2};
      4'd14: entry_o = {NOTE_C4, 1'b0, 4'd8};
      4'd15: entry_o = {NOTE_C4, 1'b1, 4'd4};
      default: entry_o = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/piano_seq_ctrl.sv
// ============================================================================
// piano_seq_ctrl : drives the piano note enable from debounced keys or autoplay
// Rev 1.0
// ============================================================================
`default_nettype none

module piano_seq_ctrl
  import piano_seq_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 250000,
  parameter int unsigned GAP_TICKS  = 1,
  parameter int unsigned DEB_CYCLES = 20000,
  parameter int unsigned SONG_LEN   = 16
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [7:0] keys_i,
  input  logic       play_i,
  input  logic       stop_i,
  output logic [7:0] note_en_o,
  output logic       busy_o,
  output logic [3:0] step_o,
  output logic       done_o
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned TCNT_W = 8;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TCNT_W-1:0] GAP_LAST  = TCNT_W'(GAP_TICKS - 1);
  localparam logic [3:0]        STEP_LAST = 4'(SONG_LEN - 1);
  localparam logic              HAS_GAP   = (GAP_TICKS > 0);

  logic [7:0] sync1_q, sync2_q;
  logic [7:0] key_acc;

  state_e            state_q, state_d;
  logic [3:0]        step_q, step_d;
  logic              done_q, done_d;
  logic [7:0]        key_note_q, key_note_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [TCNT_W-1:0] dur_last;
  logic [7:0]        rom_entry;
  logic              tick;
  logic              restart;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= keys_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_deb
    logic             acc_q;
    logic [DEB_W-1:0] cnt_q;

    // Counter only advances while the synchronised level disagrees with the accepted one.
    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        acc_q <= 1'b0;
        cnt_q <= '0;
      end else if (sync2_q[k] == acc_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEB_LAST) begin
        acc_q <= sync2_q[k];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign key_acc[k] = acc_q;
  end

  piano_song_rom u_rom (
    .addr_i  (step_q),
    .entry_o (rom_entry)
  );

  assign tick     = (tick_q == TICK_LAST);
  assign dur_last = TCNT_W'(entry_ticks(rom_entry)) - TCNT_W'(1);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    done_d  = 1'b0;
    restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (play_i && !stop_i) begin
          state_d = ST_NOTE;
          step_d  = 4'd0;
          restart = 1'b1;
        end
      end
      ST_NOTE, ST_GAP: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          step_d  = 4'd0;
          restart = 1'b1;
        end else if (state_q == ST_NOTE && tick && tcnt_q == dur_last && HAS_GAP) begin
          state_d = ST_GAP;
          restart = 1'b1;
        end else if (tick && ((state_q == ST_NOTE && tcnt_q == dur_last) ||
                              (state_q == ST_GAP  && tcnt_q == GAP_LAST))) begin
          restart = 1'b1;
          if (step_q == STEP_LAST) begin
            state_d = ST_IDLE;
            step_d  = 4'd0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_NOTE;
            step_d  = step_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = 4'd0;
        restart = 1'b1;
      end
    endcase
  end

  always_comb begin
    tick_d = tick_q + 1'b1;
    tcnt_d = tcnt_q;
    if (restart) begin
      tick_d = '0;
      tcnt_d = '0;
    end else if (tick) begin
      tick_d = '0;
      tcnt_d = tcnt_q + 1'b1;
    end
  end

  // Cleared while busy so the first idle cycle after a song is silent.
  assign key_note_d = (state_q == ST_IDLE) ? lowest_onehot(key_acc) : 8'h00;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      step_q     <= 4'd0;
      done_q     <= 1'b0;
      key_note_q <= 8'h00;
      tick_q     <= '0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      done_q     <= done_d;
      key_note_q <= key_note_d;
      tick_q     <= tick_d;
      tcnt_q     <= tcnt_d;
    end
  end

  always_comb begin
    note_en_o = 8'h00;
    case (state_q)
      ST_IDLE: note_en_o = key_note_q;
      ST_NOTE: note_en_o = entry_note_en(rom_entry);
      default: note_en_o = 8'h00;
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);
  assign step_o = step_q;
  assign done_o = done_q;

endmodule

`default_nettype wire
